tvm_input_conditioner: RTL

Front-end stage of the ticket vending machine. It takes the raw coin-acceptor and selection-key lines, synchronizes and debounces them, and queues each press or coin as an event. It delivers each event to the main fare FSM on its 8-bit one-hot `DATA_inm` bus as a single-cycle pulse followed by at least one idle (all-zero) cycle. Events are issued only while the FSM signals it can take input.

---
 rtl/tvm_input_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tvm_input_conditioner.sv
// rtl/tvm_input_conditioner.sv - coin/key synchronizer, debouncer, event queue and one-hot pulse issuer
module tvm_input_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clkm,
  input  logic       rstm,
  input  logic [7:0] raw_in,
  input  logic       enable,
  input  logic       flush,
  output logic [7:0] data_out,
  output logic [2:0] pending_cnt,
  output logic       overflow
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [7:0]    s1, s;
  logic [CW-1:0] cnt [8];
  logic [7:0]    stable, stable_d, rise;
  logic [7:0]    pend, push_mask;
  logic [2:0]    push_idx;
  logic          push, pop;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          full, empty;
  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          gap_last;

  // Two-flop synchronizer for the asynchronous acceptor/key lines
  always_ff @(posedge clkm) begin
    if (!rstm) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= raw_in;
      s  <= s1;
    end
  end

  // Per-line debounce: state flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clkm) begin
    if (!rstm) begin
      stable <= '0;
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (s[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CW'(DEB_CYCLES - 1)) begin
          stable[k] <= ~stable[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_d;

  // Lowest-index pending line wins the single push slot
  always_comb begin
    push_idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (pend[k]) push_idx = 3'(k);
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = (|pend) && (!full || pop) && !flush;
  assign push_mask = push ? (8'd1 << push_idx) : 8'd0;

  // Edge history, pending bits and sticky overflow; a rise on an already pending line is lost
  always_ff @(posedge clkm) begin
    if (!rstm) begin
      stable_d <= '0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      stable_d <= stable;
      if (flush) begin
        pend     <= '0;
        overflow <= 1'b0;
      end else begin
        pend     <= (pend & ~push_mask) | rise;
        overflow <= overflow | (|(rise & pend & ~push_mask));
      end
    end
  end

  // Event queue storage and pointers; push and pop may coincide even when full
  always_ff @(posedge clkm) begin
    if (!rstm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_idx;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy seen by the FSM host, saturating at 7
  always_comb begin
    pending_cnt = (int'(count) > 7) ? 3'd7 : 3'(count);
  end

  // The last GAP cycle doubles as the IDLE decision point so back-to-back pulses are GAP_CYCLES+1 apart
  always_comb begin
    state_nxt = state;
    gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));
    pop       = ((state == IDLE) || ((state == GAP) && gap_last)) && !empty && enable && !flush;
    case (state)
      IDLE:    if (pop) state_nxt = PULSE;
      PULSE:   state_nxt = GAP;
      GAP: begin
        if (pop)           state_nxt = PULSE;
        else if (gap_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Issue state, gap counter and registered one-hot pulse
  always_ff @(posedge clkm) begin
    if (!rstm) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      data_out <= '0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= ((state == GAP) && (state_nxt == GAP)) ? gap_cnt + 1'b1 : '0;
      data_out <= pop ? (8'd1 << mem[rd_ptr[AW-1:0]]) : 8'd0;
    end
  end

endmodule
